// File: rtl/id_ex_stage_if.sv
// Bundle of decode-side, forwarding and ALU-side signals around the ID/EX register.
// slave = the stage itself, master = whoever drives decode/forwarding and consumes the ALU op.
interface id_ex_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            funct3;
    logic                  funct7b5;
    logic                  is_rtype;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  reg_write;
    logic                  ex_fwd_en;
    logic [REG_ADDR_W-1:0] ex_fwd_rd;
    logic [XLEN-1:0]       ex_fwd_data;
    logic                  wb_fwd_en;
    logic [REG_ADDR_W-1:0] wb_fwd_rd;
    logic [XLEN-1:0]       wb_fwd_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [3:0]            aluSel;
    logic [XLEN-1:0]       alu_a;
    logic [XLEN-1:0]       alu_b;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_reg_write;
    logic [CNT_W-1:0]      stall_cycles;

    // Handshake: a beat moves when valid && ready on the same rising edge; a producer
    // holding valid keeps its payload stable until that edge.
    modport master (
        output flush, in_valid, funct3, funct7b5, is_rtype, rs1_addr, rs2_addr,
               rs1_data, rs2_data, imm, rd_addr, reg_write, ex_fwd_en, ex_fwd_rd,
               ex_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data, out_ready,
        input  in_ready, out_valid, aluSel, alu_a, alu_b, out_rd, out_reg_write,
               stall_cycles
    );

    modport slave (
        input  flush, in_valid, funct3, funct7b5, is_rtype, rs1_addr, rs2_addr,
               rs1_data, rs2_data, imm, rd_addr, reg_write, ex_fwd_en, ex_fwd_rd,
               ex_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data, out_ready,
        output in_ready, out_valid, aluSel, alu_a, alu_b, out_rd, out_reg_write,
               stall_cycles
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: resolves EX/WB forwarding at capture, builds aluSel and
// ALU operands, and counts back-pressure cycles with a saturating counter.
module id_ex_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);
    logic                  accept;
    logic                  shift_op;
    logic                  sel_b0;
    logic [XLEN-1:0]       rs1_fwd;
    logic [XLEN-1:0]       rs2_fwd;
    logic [XLEN-1:0]       b_val;

    logic                  valid_q;
    logic [3:0]            sel_q;
    logic [XLEN-1:0]       a_q;
    logic [XLEN-1:0]       b_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  rw_q;
    logic [CNT_W-1:0]      cnt_q;

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        rs1_fwd = bus.rs1_data;
        if (bus.rs1_addr == '0)
            rs1_fwd = '0;
        else if (bus.ex_fwd_en && bus.ex_fwd_rd == bus.rs1_addr)
            rs1_fwd = bus.ex_fwd_data;
        else if (bus.wb_fwd_en && bus.wb_fwd_rd == bus.rs1_addr)
            rs1_fwd = bus.wb_fwd_data;

        rs2_fwd = bus.rs2_data;
        if (bus.rs2_addr == '0)
            rs2_fwd = '0;
        else if (bus.ex_fwd_en && bus.ex_fwd_rd == bus.rs2_addr)
            rs2_fwd = bus.ex_fwd_data;
        else if (bus.wb_fwd_en && bus.wb_fwd_rd == bus.rs2_addr)
            rs2_fwd = bus.wb_fwd_data;

        shift_op = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd5);
        // instr[30] only means sub/sra for R-type and srai; for addi etc. it is imm bit 10
        sel_b0   = (bus.is_rtype || bus.funct3 == 3'd5) ? bus.funct7b5 : 1'b0;
        b_val    = bus.is_rtype ? rs2_fwd : bus.imm;
        if (shift_op)
            b_val[XLEN-1:5] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            sel_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            sel_q   <= {bus.funct3, sel_b0};
            a_q     <= rs1_fwd;
            b_q     <= b_val;
            rd_q    <= bus.rd_addr;
            rw_q    <= bus.reg_write;
        end else if (bus.out_ready && valid_q) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (valid_q && !bus.out_ready && cnt_q != {CNT_W{1'b1}})
            cnt_q <= cnt_q + 1'b1;
    end

    assign bus.out_valid     = valid_q;
    assign bus.aluSel        = sel_q;
    assign bus.alu_a         = a_q;
    assign bus.alu_b         = b_q;
    assign bus.out_rd        = rd_q;
    assign bus.out_reg_write = rw_q;
    assign bus.stall_cycles  = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode/forwarding vectors with hand-computed ALU
// operands, stall/flush/reset behaviour, and counter saturation on a CNT_W=2 copy.
module tb_id_ex_stage;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [67:0] exp_q[$];

    id_ex_stage_if #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(16)) b  ();
    id_ex_stage_if #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(2))  bs ();

    id_ex_stage #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(b));
    id_ex_stage #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(2))  dut_s (.clk(clk), .rst(rst), .bus(bs));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: expected {aluSel, alu_a, alu_b} per accepted op
    task automatic expect_op(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] bv);
        exp_q.push_back({sel, a, bv});
    endtask

    task automatic check_op(input string tag);
        logic [67:0] e;
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check_val({tag, "_sel"}, 64'(b.aluSel), 64'(e[67:64]));
            check_val({tag, "_a"},   64'(b.alu_a),  64'(e[63:32]));
            check_val({tag, "_b"},   64'(b.alu_b),  64'(e[31:0]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver
    task automatic drive_op(input logic [2:0] f3, input logic b5, input logic rt,
                            input logic [4:0] r1, input logic [4:0] r2,
                            input logic [31:0] d1, input logic [31:0] d2,
                            input logic [31:0] iv, input logic [4:0] rd, input logic rw);
        b.in_valid  = 1'b1;
        b.funct3    = f3;
        b.funct7b5  = b5;
        b.is_rtype  = rt;
        b.rs1_addr  = r1;
        b.rs2_addr  = r2;
        b.rs1_data  = d1;
        b.rs2_data  = d2;
        b.imm       = iv;
        b.rd_addr   = rd;
        b.reg_write = rw;
    endtask

    task automatic set_fwd(input logic ee, input logic [4:0] erd, input logic [31:0] ed,
                           input logic we, input logic [4:0] wrd, input logic [31:0] wd);
        b.ex_fwd_en = ee; b.ex_fwd_rd = erd; b.ex_fwd_data = ed;
        b.wb_fwd_en = we; b.wb_fwd_rd = wrd; b.wb_fwd_data = wd;
    endtask

    task automatic init_small();
        bs.flush = 0; bs.in_valid = 0; bs.funct3 = 0; bs.funct7b5 = 0; bs.is_rtype = 1;
        bs.rs1_addr = 0; bs.rs2_addr = 0; bs.rs1_data = 0; bs.rs2_data = 0; bs.imm = 0;
        bs.rd_addr = 0; bs.reg_write = 0; bs.ex_fwd_en = 0; bs.ex_fwd_rd = 0;
        bs.ex_fwd_data = 0; bs.wb_fwd_en = 0; bs.wb_fwd_rd = 0; bs.wb_fwd_data = 0;
        bs.out_ready = 1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        b.flush = 0;
        b.out_ready = 1;
        drive_op(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        b.in_valid = 0;
        set_fwd(0, 0, 0, 0, 0, 0);
        init_small();
        #12;
        check_val("rst_out_valid", 64'(b.out_valid), 64'd0);
        check_val("rst_in_ready", 64'(b.in_ready), 64'd1);
        check_val("rst_stall", 64'(b.stall_cycles), 64'd0);
        check_val("rst_sel", 64'(b.aluSel), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // R-type sub
        drive_op(3'd0, 1, 1, 5'd1, 5'd2, 32'd5, 32'd3, 32'd0, 5'd4, 1);
        expect_op(4'b0001, 32'd5, 32'd3);
        step();
        b.in_valid = 0;
        check_val("sub_valid", 64'(b.out_valid), 64'd1);
        check_op("sub");
        check_val("sub_rd", 64'(b.out_rd), 64'd4);
        check_val("sub_rw", 64'(b.out_reg_write), 64'd1);

        // addi with imm bit 10 set must not subtract
        drive_op(3'd0, 1, 0, 5'd6, 5'd0, 32'd9, 32'd0, 32'h400, 5'd5, 1);
        expect_op(4'b0000, 32'd9, 32'h400);
        step();
        check_op("addi");

        // srai: only shamt reaches the ALU
        drive_op(3'd5, 1, 0, 5'd6, 5'd0, 32'd9, 32'd0, 32'h0000_0403, 5'd5, 1);
        expect_op(4'b1011, 32'd9, 32'd3);
        step();
        check_op("srai");

        // R-type sll with large rs2
        drive_op(3'd1, 0, 1, 5'd1, 5'd2, 32'h10, 32'hFFFF_FFE3, 32'd0, 5'd6, 1);
        expect_op(4'b0010, 32'h10, 32'd3);
        step();
        check_op("sll");

        // xori: b5 ignored, immediate not masked
        drive_op(3'd4, 1, 0, 5'd1, 5'd0, 32'h77, 32'd0, 32'hFFFF_F800, 5'd7, 0);
        expect_op(4'b1000, 32'h77, 32'hFFFF_F800);
        step();
        check_op("xori");
        check_val("xori_rw", 64'(b.out_reg_write), 64'd0);

        // EX beats WB on rs1; rs2 from register file
        set_fwd(1, 5'd7, 32'hAA, 1, 5'd7, 32'hBB);
        drive_op(3'd0, 0, 1, 5'd7, 5'd9, 32'd11, 32'd22, 32'd0, 5'd3, 1);
        expect_op(4'b0000, 32'hAA, 32'd22);
        step();
        check_op("fwd_ex");

        // WB-only on rs1, EX on rs2
        set_fwd(1, 5'd3, 32'hDD, 1, 5'd9, 32'hCC);
        drive_op(3'd0, 0, 1, 5'd9, 5'd3, 32'd11, 32'd22, 32'd0, 5'd3, 1);
        expect_op(4'b0000, 32'hCC, 32'hDD);
        step();
        check_op("fwd_wb");

        // x0 is never forwarded
        set_fwd(1, 5'd0, 32'h55, 1, 5'd0, 32'h66);
        drive_op(3'd0, 0, 1, 5'd0, 5'd0, 32'h77, 32'h88, 32'd0, 5'd3, 1);
        expect_op(4'b0000, 32'd0, 32'd0);
        step();
        check_op("fwd_x0");

        // stall 3 cycles: held op keeps its captured forwarding result
        set_fwd(1, 5'd1, 32'h123, 0, 5'd0, 32'd0);
        drive_op(3'd2, 0, 1, 5'd1, 5'd2, 32'd100, 32'd200, 32'd0, 5'd8, 1);
        step();
        b.out_ready = 0;
        b.ex_fwd_data = 32'h999;
        drive_op(3'd7, 1, 1, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 5'd9, 0);
        for (int i = 0; i < 3; i++) begin
            expect_op(4'b0100, 32'h123, 32'd200);
            step();
            check_val("stall_valid", 64'(b.out_valid), 64'd1);
            check_val("stall_in_ready", 64'(b.in_ready), 64'd0);
            check_op("stall_hold");
        end
        check_val("stall_count", 64'(b.stall_cycles), 64'd3);
        b.out_ready = 1;
        b.in_valid = 0;
        set_fwd(0, 0, 0, 0, 0, 0);
        step();
        check_val("drain_valid", 64'(b.out_valid), 64'd0);
        check_val("drain_rw", 64'(b.out_reg_write), 64'd0);
        check_val("drain_count", 64'(b.stall_cycles), 64'd3);

        // flush drops both held op and the op offered this cycle
        drive_op(3'd0, 0, 1, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 5'd9, 1);
        step();
        check_val("preflush_valid", 64'(b.out_valid), 64'd1);
        b.flush = 1;
        drive_op(3'd0, 0, 1, 5'd1, 5'd2, 32'd3, 32'd4, 32'd0, 5'd10, 1);
        step();
        b.flush = 0;
        b.in_valid = 0;
        check_val("flush_valid", 64'(b.out_valid), 64'd0);
        check_val("flush_rw", 64'(b.out_reg_write), 64'd0);
        check_val("flush_in_ready", 64'(b.in_ready), 64'd1);

        // asynchronous reset while holding an op
        drive_op(3'd0, 1, 1, 5'd1, 5'd2, 32'd5, 32'd3, 32'd0, 5'd4, 1);
        step();
        b.in_valid = 0;
        b.out_ready = 0;
        step();
        check_val("hold_count", 64'(b.stall_cycles), 64'd4);
        check_val("hold_valid", 64'(b.out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_valid", 64'(b.out_valid), 64'd0);
        check_val("arst_sel", 64'(b.aluSel), 64'd0);
        check_val("arst_a", 64'(b.alu_a), 64'd0);
        check_val("arst_b", 64'(b.alu_b), 64'd0);
        check_val("arst_rd", 64'(b.out_rd), 64'd0);
        check_val("arst_rw", 64'(b.out_reg_write), 64'd0);
        check_val("arst_count", 64'(b.stall_cycles), 64'd0);
        check_val("arst_in_ready", 64'(b.in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        b.out_ready = 1;

        // saturation on the 2-bit counter
        bs.out_ready = 0;
        bs.in_valid = 1;
        bs.reg_write = 1;
        step();
        bs.in_valid = 0;
        check_val("sat_valid", 64'(bs.out_valid), 64'd1);
        check_val("sat_start", 64'(bs.stall_cycles), 64'd0);
        for (int i = 0; i < 5; i++) step();
        check_val("sat_count", 64'(bs.stall_cycles), 64'd3);
        check_val("sat_hold", 64'(bs.out_valid), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
